// File: rtl/uart_tx_cfg_if.sv
// Parallel request / serial status bundle between a UART TX client and uart_tx_cfg.
// master = client driving words and frame options, slave = the transmitter.
interface uart_tx_cfg_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  STOP2;
  logic [PRESC_W-1:0]    PRESCALE;
  logic                  TX_OUT;
  logic                  Busy;
  logic                  TX_DONE;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2, PRESCALE,
    input  TX_OUT, Busy, TX_DONE
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2, PRESCALE,
    output TX_OUT, Busy, TX_DONE
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// UART transmitter: start, DATA_WIDTH bits LSB-first, optional parity, 1/2 stops; PRESCALE clks per bit.
// Line drops on the accepting edge; DATA_VALID is ignored while Busy, no queueing.
module uart_tx_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 8
) (
  input  logic         CLK,
  input  logic         RST,
  uart_tx_cfg_if.slave bus
);
  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
  localparam logic [PRESC_W-1:0] P_ONE    = PRESC_W'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_nxt;
  logic [PRESC_W-1:0]    cnt, cnt_nxt;
  logic [PRESC_W-1:0]    presc_q, presc_nxt;
  logic [DATA_WIDTH-1:0] sh_q, sh_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic                  par_en_q, par_en_nxt;
  logic                  par_q, par_nxt;
  logic                  stop2_q, stop2_nxt;
  logic                  stop_idx, stop_idx_nxt;
  logic                  tx_q, tx_nxt;
  logic                  busy_q, busy_nxt;
  logic                  done_q, done_nxt;
  logic                  bit_end;

  assign bit_end = (cnt == '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      cnt      <= '0;
      presc_q  <= '0;
      sh_q     <= '0;
      idx      <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
      stop_idx <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      presc_q  <= presc_nxt;
      sh_q     <= sh_nxt;
      idx      <= idx_nxt;
      par_en_q <= par_en_nxt;
      par_q    <= par_nxt;
      stop2_q  <= stop2_nxt;
      stop_idx <= stop_idx_nxt;
      tx_q     <= tx_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    presc_nxt    = presc_q;
    sh_nxt       = sh_q;
    idx_nxt      = idx;
    par_en_nxt   = par_en_q;
    par_nxt      = par_q;
    stop2_nxt    = stop2_q;
    stop_idx_nxt = stop_idx;
    tx_nxt       = tx_q;
    busy_nxt     = busy_q;
    done_nxt     = 1'b0;

    // Every non-idle bit lasts presc_q cycles: count down, reload on expiry.
    if (state != IDLE) begin
      cnt_nxt = bit_end ? (presc_q - P_ONE) : (cnt - P_ONE);
    end

    case (state)
      IDLE: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        if (bus.DATA_VALID) begin
          presc_nxt  = (bus.PRESCALE == '0) ? P_ONE : bus.PRESCALE;
          cnt_nxt    = (bus.PRESCALE == '0) ? '0 : (bus.PRESCALE - P_ONE);
          sh_nxt     = bus.P_DATA;
          par_en_nxt = bus.PAR_EN;
          par_nxt    = (^bus.P_DATA) ^ bus.PAR_TYP;
          stop2_nxt  = bus.STOP2;
          tx_nxt     = 1'b0;
          busy_nxt   = 1'b1;
          state_nxt  = START;
        end
      end
      START: begin
        if (bit_end) begin
          idx_nxt   = '0;
          tx_nxt    = sh_q[0];
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx == IDX_LAST) begin
            tx_nxt       = par_en_q ? par_q : 1'b1;
            stop_idx_nxt = 1'b0;
            state_nxt    = par_en_q ? PARITY : STOP;
          end else begin
            idx_nxt = idx + IDX_ONE;
            tx_nxt  = sh_q[1];
            sh_nxt  = sh_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          tx_nxt       = 1'b1;
          stop_idx_nxt = 1'b0;
          state_nxt    = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_idx) begin
            stop_idx_nxt = 1'b1;
          end else begin
            cnt_nxt   = '0;
            tx_nxt    = 1'b1;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.TX_OUT  = tx_q;
  assign bus.Busy    = busy_q;
  assign bus.TX_DONE = done_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: an 8-bit and a 5-bit instance share clock and reset;
// expected line levels are queued per cycle at drive time and popped as the DUT shifts.
module tb_uart_tx_cfg;
  logic CLK = 1'b0;
  logic RST;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   q_tx[$];

  always #5 CLK = ~CLK;

  uart_tx_cfg_if #(.DATA_WIDTH(8), .PRESC_W(8)) b8 ();
  uart_tx_cfg_if #(.DATA_WIDTH(5), .PRESC_W(8)) b5 ();

  uart_tx_cfg #(.DATA_WIDTH(8), .PRESC_W(8)) dut8 (.CLK(CLK), .RST(RST), .bus(b8));
  uart_tx_cfg #(.DATA_WIDTH(5), .PRESC_W(8)) dut5 (.CLK(CLK), .RST(RST), .bus(b5));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic tx_of(bit sel);
    return sel ? b5.TX_OUT : b8.TX_OUT;
  endfunction
  function automatic logic busy_of(bit sel);
    return sel ? b5.Busy : b8.Busy;
  endfunction
  function automatic logic done_of(bit sel);
    return sel ? b5.TX_DONE : b8.TX_DONE;
  endfunction

  task automatic set_dv(bit sel, bit v);
    if (sel) b5.DATA_VALID = v;
    else     b8.DATA_VALID = v;
  endtask

  task automatic drive_inputs(logic [8:0] d, bit pe, bit pt, bit s2, logic [7:0] presc);
    b8.P_DATA = d[7:0];  b5.P_DATA = d[4:0];
    b8.PAR_EN = pe;      b5.PAR_EN = pe;
    b8.PAR_TYP = pt;     b5.PAR_TYP = pt;
    b8.STOP2 = s2;       b5.STOP2 = s2;
    b8.PRESCALE = presc; b5.PRESCALE = presc;
  endtask

  // Reference frame: start, data LSB-first, parity, stop(s); each level repeated P times.
  task automatic push_frame(int w, logic [8:0] d, bit pe, bit pt, bit s2, int presc, output int len);
    int p;
    bit par;
    bit bits[$];
    p = (presc == 0) ? 1 : presc;
    bits.push_back(1'b0);
    for (int i = 0; i < w; i++) bits.push_back(d[i]);
    if (pe) begin
      par = pt;
      for (int i = 0; i < w; i++) par = par ^ d[i];
      bits.push_back(par);
    end
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    foreach (bits[k]) repeat (p) q_tx.push_back(bits[k]);
    len = bits.size() * p;
  endtask

  task automatic run_frame(bit sel, logic [8:0] d, bit pe, bit pt, bit s2, logic [7:0] presc,
                           int poke, bit keep, bit chained);
    int  len;
    bit  e;
    if (!chained) @(negedge CLK);
    drive_inputs(d, pe, pt, s2, presc);
    set_dv(sel, 1'b1);
    push_frame(sel ? 5 : 8, d, pe, pt, s2, int'(presc), len);
    @(posedge CLK);
    for (int c = 0; c < len; c++) begin
      @(negedge CLK);
      if (c == 0 && !keep) set_dv(sel, 1'b0);
      if (c == poke) begin
        b8.P_DATA = 8'hFF;
        b5.P_DATA = 5'h1F;
        set_dv(sel, 1'b1);
      end
      if (c == poke + 1) set_dv(sel, 1'b0);
      e = q_tx.pop_front();
      chk("tx_bit", 32'(tx_of(sel)), 32'(e));
      chk("busy_in_frame", 32'(busy_of(sel)), 32'd1);
      chk("done_in_frame", 32'(done_of(sel)), 32'd0);
    end
    @(negedge CLK);
    chk("done_pulse", 32'(done_of(sel)), 32'd1);
    chk("busy_fall", 32'(busy_of(sel)), 32'd0);
    chk("tx_idle_after", 32'(tx_of(sel)), 32'd1);
  endtask

  initial begin
    RST = 1'b1;
    b8.DATA_VALID = 1'b0;
    b5.DATA_VALID = 1'b0;
    drive_inputs(9'h0, 1'b0, 1'b0, 1'b0, 8'd0);
    #2 RST = 1'b0;

    // Reset and idle
    repeat (3) @(negedge CLK);
    chk("rst_tx8", 32'(b8.TX_OUT), 32'd1);
    chk("rst_busy8", 32'(b8.Busy), 32'd0);
    chk("rst_done8", 32'(b8.TX_DONE), 32'd0);
    chk("rst_tx5", 32'(b5.TX_OUT), 32'd1);
    RST = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      chk("idle_tx", 32'(b8.TX_OUT), 32'd1);
      chk("idle_busy", 32'(b8.Busy), 32'd0);
      chk("idle_done", 32'(b8.TX_DONE), 32'd0);
    end

    // Basic, parity/stop variants, narrow width and prescale extremes
    run_frame(1'b0, 9'h0A5, 1'b0, 1'b0, 1'b0, 8'd1, -1, 1'b0, 1'b0);
    run_frame(1'b0, 9'h007, 1'b1, 1'b0, 1'b1, 8'd4, -1, 1'b0, 1'b0);
    run_frame(1'b0, 9'h007, 1'b1, 1'b1, 1'b1, 8'd4, -1, 1'b0, 1'b0);
    run_frame(1'b1, 9'h01F, 1'b0, 1'b0, 1'b0, 8'd0, -1, 1'b0, 1'b0);
    run_frame(1'b1, 9'h00B, 1'b1, 1'b1, 1'b0, 8'd3, -1, 1'b0, 1'b0);
    run_frame(1'b0, 9'h0A5, 1'b0, 1'b0, 1'b0, 8'd255, -1, 1'b0, 1'b0);

    // Mid-frame request with changed data must be ignored
    run_frame(1'b0, 9'h03C, 1'b0, 1'b0, 1'b0, 8'd2, 7, 1'b0, 1'b0);
    repeat (6) begin
      @(negedge CLK);
      chk("lockout_busy", 32'(b8.Busy), 32'd0);
      chk("lockout_tx", 32'(b8.TX_OUT), 32'd1);
    end

    // Back-to-back with DATA_VALID held through TX_DONE
    run_frame(1'b0, 9'h096, 1'b1, 1'b0, 1'b0, 8'd2, -1, 1'b1, 1'b0);
    run_frame(1'b0, 9'h069, 1'b0, 1'b0, 1'b1, 8'd1, -1, 1'b0, 1'b1);

    // Reset during data bit 3 (0x52 has bit 3 = 0), then a clean frame
    @(negedge CLK);
    drive_inputs(9'h052, 1'b0, 1'b0, 1'b0, 8'd4);
    b8.DATA_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    b8.DATA_VALID = 1'b0;
    repeat (17) @(negedge CLK);
    chk("pre_reset_bit3", 32'(b8.TX_OUT), 32'd0);
    RST = 1'b0;
    #1;
    chk("abort_tx", 32'(b8.TX_OUT), 32'd1);
    chk("abort_busy", 32'(b8.Busy), 32'd0);
    chk("abort_done", 32'(b8.TX_DONE), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("post_rst_done", 32'(b8.TX_DONE), 32'd0);
      chk("post_rst_tx", 32'(b8.TX_OUT), 32'd1);
    end
    run_frame(1'b0, 9'h0C3, 1'b1, 1'b1, 1'b0, 8'd2, -1, 1'b0, 1'b0);

    chk("queue_drained", 32'(q_tx.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
